// File: rtl/token_gate_controller.sv
// Token-gated access controller: token check with lockout, then two-deep capture of TimeData words.
// Latency: one clock from confirm to data_P/data_valid; granted two clocks after request with a matching token.
// Backpressure: none; confirm in GRANT captures every clock. Optional STICKY_LOCK_EN holds LOCK until reset.
module token_gate_controller #(
   parameter int TOKEN_W      = 3,
   parameter int DATA_W       = 8,
   parameter int MAX_TRIES    = 3,
   parameter int LOCK_CYCLES  = 16,
   parameter int AUTH_TIMEOUT = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [TOKEN_W-1:0]             system_token,
   input  logic                           request,
   input  logic                           confirm,
   input  logic [TOKEN_W-1:0]             user_token,
   input  logic [DATA_W-1:0]              TimeData,
   output logic [DATA_W-1:0]              data_P,
   output logic [DATA_W-1:0]              data_Q,
   output logic                           data_valid,
   output logic                           granted,
   output logic                           locked,
   output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

   localparam int FW = $clog2(MAX_TRIES + 1);
   // Timer widths collapse to one bit when the limit is 1 so the vectors stay legal.
   localparam int AW = (AUTH_TIMEOUT > 1) ? $clog2(AUTH_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, AUTH, GRANT, LOCK} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   auth_tmr, auth_tmr_nxt;
   logic [FW-1:0]   fail_cnt_nxt;
   logic [FW-1:0]   fail_inc;
   logic            cap;

`ifndef STICKY_LOCK_EN
   localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   logic [LW-1:0]   lock_tmr, lock_tmr_nxt;

   // Lockout timer, restarted on every entry into LOCK.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) lock_tmr <= '0;
      else        lock_tmr <= lock_tmr_nxt;
   end
`endif

   assign fail_inc = fail_cnt + 1'b1;

   // State, AUTH timer and failure counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         auth_tmr <= '0;
         fail_cnt <= '0;
      end else begin
         state    <= state_nxt;
         auth_tmr <= auth_tmr_nxt;
         fail_cnt <= fail_cnt_nxt;
      end
   end

   // Next-state logic; AUTH priority is request drop, then token confirm, then timeout.
   always_comb begin
      state_nxt    = state;
      auth_tmr_nxt = auth_tmr;
      fail_cnt_nxt = fail_cnt;
      cap          = 1'b0;
`ifndef STICKY_LOCK_EN
      lock_tmr_nxt = lock_tmr;
`endif
      case (state)
         IDLE: begin
            if (request) begin
               state_nxt    = AUTH;
               auth_tmr_nxt = '0;
            end
         end
         AUTH: begin
            if (!request) begin
               state_nxt = IDLE;
            end else if (confirm) begin
               if (user_token == system_token) begin
                  state_nxt    = GRANT;
                  fail_cnt_nxt = '0;
               end else begin
                  fail_cnt_nxt = fail_inc;
                  if (fail_inc == FW'(MAX_TRIES)) begin
                     state_nxt = LOCK;
`ifndef STICKY_LOCK_EN
                     lock_tmr_nxt = '0;
`endif
                  end else begin
                     auth_tmr_nxt = '0;
                  end
               end
            end else if (auth_tmr == AW'(AUTH_TIMEOUT - 1)) begin
               // Timeout is not a failed try: fail_cnt is left alone.
               state_nxt = IDLE;
            end else begin
               auth_tmr_nxt = auth_tmr + 1'b1;
            end
         end
         GRANT: begin
            if (!request)     state_nxt = IDLE;
            else if (confirm) cap       = 1'b1;
         end
         LOCK: begin
`ifndef STICKY_LOCK_EN
            if (lock_tmr == LW'(LOCK_CYCLES - 1)) begin
               state_nxt    = IDLE;
               fail_cnt_nxt = '0;
            end else begin
               lock_tmr_nxt = lock_tmr + 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Two-deep capture history; values persist after leaving GRANT.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_P     <= '0;
         data_Q     <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= cap;
         if (cap) begin
            data_Q <= data_P;
            data_P <= TimeData;
         end
      end
   end

   assign granted = (state == GRANT);
   assign locked  = (state == LOCK);

endmodule

// File: tb/tb_token_gate_controller.sv
// Directed bench for token_gate_controller with hand-computed expectations.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
// Honours STICKY_LOCK_EN when the design is built with it.
module tb_token_gate_controller;

   logic       clock;
   logic       reset;
   logic [2:0] system_token;
   logic       request;
   logic       confirm;
   logic [2:0] user_token;
   logic [7:0] TimeData;
   logic [7:0] data_P;
   logic [7:0] data_Q;
   logic       data_valid;
   logic       granted;
   logic       locked;
   logic [1:0] fail_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   token_gate_controller #(
      .TOKEN_W(3), .DATA_W(8), .MAX_TRIES(3), .LOCK_CYCLES(16), .AUTH_TIMEOUT(8)
   ) dut (
      .clock(clock), .reset(reset), .system_token(system_token), .request(request),
      .confirm(confirm), .user_token(user_token), .TimeData(TimeData),
      .data_P(data_P), .data_Q(data_Q), .data_valid(data_valid),
      .granted(granted), .locked(locked), .fail_cnt(fail_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; system_token = 3'b101; request = 1'b0; confirm = 1'b0;
      user_token = 3'b000; TimeData = 8'h00;
      step(); step();
      chk("rst_data_P", data_P, 0);
      chk("rst_data_Q", data_Q, 0);
      chk("rst_fail_cnt", fail_cnt, 0);
      chk("rst_granted", granted, 0);
      chk("rst_locked", locked, 0);
      chk("rst_data_valid", data_valid, 0);
      reset = 1'b1;
      step();

      // Grant and single capture.
      request = 1'b1;
      step();
      chk("auth_not_granted", granted, 0);
      confirm = 1'b1; user_token = 3'b101;
      step();
      chk("granted_2clk", granted, 1);
      TimeData = 8'hF2;
      step();
      chk("cap_F2_P", data_P, 8'hF2);
      chk("cap_F2_vld", data_valid, 1);
      confirm = 1'b0;
      step();
      chk("vld_single_pulse", data_valid, 0);

      // Back-to-back capture.
      confirm = 1'b1; TimeData = 8'h11;
      step();
      chk("b2b_11_P", data_P, 8'h11);
      chk("b2b_11_Q", data_Q, 8'hF2);
      chk("b2b_11_vld", data_valid, 1);
      TimeData = 8'h22;
      step();
      chk("b2b_22_P", data_P, 8'h22);
      chk("b2b_22_Q", data_Q, 8'h11);
      chk("b2b_22_vld", data_valid, 1);
      confirm = 1'b0; request = 1'b0;
      step();
      chk("grant_exit", granted, 0);
      chk("hold_P", data_P, 8'h22);
      chk("hold_Q", data_Q, 8'h11);

      // Lockout on three mismatches.
      request = 1'b1;
      step();
      confirm = 1'b1; user_token = 3'b100;
      step();
      chk("fail1", fail_cnt, 1);
      chk("fail1_unlocked", locked, 0);
      step();
      chk("fail2", fail_cnt, 2);
      chk("fail2_unlocked", locked, 0);
      step();
      chk("fail3", fail_cnt, 3);
      chk("fail3_locked", locked, 1);
      user_token = 3'b101;
      for (int i = 1; i < 16; i++) begin
         step();
         chk($sformatf("lock_hold_%0d", i), locked, 1);
      end
      step();
`ifdef STICKY_LOCK_EN
      chk("sticky_still_locked", locked, 1);
      reset = 1'b0;
      #1;
      chk("sticky_reset_unlock", locked, 0);
      chk("sticky_reset_fail", fail_cnt, 0);
      reset = 1'b1;
      step();
      step();
      chk("sticky_reauth_grant", granted, 1);
`else
      chk("lock_exit", locked, 0);
      chk("lock_exit_fail", fail_cnt, 0);
      chk("lock_exit_idle", granted, 0);
      step();
      chk("post_lock_auth", granted, 0);
      step();
      chk("post_lock_grant", granted, 1);
`endif
      request = 1'b0; confirm = 1'b0;
      step();

      // AUTH timeout after one failed try.
      request = 1'b1;
      step();
      confirm = 1'b1; user_token = 3'b100;
      step();
      chk("to_fail1", fail_cnt, 1);
      confirm = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("to_no_grant_%0d", i), granted, 0);
      end
      chk("to_fail_kept", fail_cnt, 1);
      // Back in IDLE, so a correct confirm only reaches AUTH this edge.
      confirm = 1'b1; user_token = 3'b101;
      step();
      chk("to_idle_then_auth", granted, 0);
      step();
      chk("to_regrant", granted, 1);
      chk("to_regrant_fail", fail_cnt, 0);

      // Async reset mid-GRANT.
      TimeData = 8'hAA;
      step();
      chk("cap_AA", data_P, 8'hAA);
      confirm = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_data_P", data_P, 0);
      chk("arst_data_Q", data_Q, 0);
      chk("arst_granted", granted, 0);
      chk("arst_vld", data_valid, 0);
      request = 1'b0;
      reset = 1'b1;
      step();

      // Request drop mid-AUTH retains fail_cnt.
      request = 1'b1;
      step();
      confirm = 1'b1; user_token = 3'b100;
      step();
      step();
      chk("drop_fail2", fail_cnt, 2);
      confirm = 1'b0; request = 1'b0;
      step();
      chk("drop_fail_kept", fail_cnt, 2);
      chk("drop_idle", granted, 0);

      // New system token, compared on the confirm edge.
      system_token = 3'b011; request = 1'b1;
      step();
      confirm = 1'b1; user_token = 3'b011;
      step();
      chk("newtok_grant", granted, 1);
      chk("newtok_fail_clr", fail_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
